md_sequencer: RTL and testbench

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair of the pipelined MIPS core. It sits beside the EX stage. It accepts one mult/div/mthi/mtlo command per start, holds `busy` for a fixed latency, then commits results to HI/LO. The hazard controller consumes `busy` to stall later HI/LO-using instructions in ID.

---
 rtl/md_sequencer.sv | 156 +++++++++++++++
 tb/tb_md_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// HI/LO owner for mult/div/mthi/mtlo: mult/div hold busy for MULT_CYCLES/DIV_CYCLES, then commit with a done pulse.
// mthi/mtlo land one edge after accept; start is ignored while busy and suppressed by req (no queueing).
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        req,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        wr;
    } pend_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_N = MULT_CYCLES[3:0];
    localparam logic [3:0] DIV_N  = DIV_CYCLES[3:0];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    pend_t       pend_q, pend_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, dsr_s, dsr_u;
    logic [31:0] quo_mag, rem_mag, quo_s, rem_s, quo_u, rem_u;
    logic        div_zero;
    pend_t       res;
    logic [3:0]  lat;
    logic        accept;

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no special case.
    always_comb begin
        prod_s   = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
        prod_u   = {32'd0, src_a} * {32'd0, src_b};
        abs_a    = src_a[31] ? (32'd0 - src_a) : src_a;
        abs_b    = src_b[31] ? (32'd0 - src_b) : src_b;
        div_zero = (src_b == 32'd0);
        dsr_s    = div_zero ? 32'd1 : abs_b;
        dsr_u    = div_zero ? 32'd1 : src_b;
        quo_mag  = abs_a / dsr_s;
        rem_mag  = abs_a % dsr_s;
        quo_s    = (src_a[31] ^ src_b[31]) ? (32'd0 - quo_mag) : quo_mag;
        rem_s    = src_a[31] ? (32'd0 - rem_mag) : rem_mag;
        quo_u    = src_a / dsr_u;
        rem_u    = src_a % dsr_u;
    end

    always_comb begin
        res = '{hi: 32'd0, lo: 32'd0, wr: 1'b0};
        lat = MULT_N;
        case (op)
            OP_MULT:  res = '{hi: prod_s[63:32], lo: prod_s[31:0], wr: 1'b1};
            OP_MULTU: res = '{hi: prod_u[63:32], lo: prod_u[31:0], wr: 1'b1};
            OP_DIV: begin
                res = '{hi: rem_s, lo: quo_s, wr: !div_zero};
                lat = DIV_N;
            end
            OP_DIVU: begin
                res = '{hi: rem_u, lo: quo_u, wr: !div_zero};
                lat = DIV_N;
            end
            default: ;
        endcase
    end

    assign accept = start && !req && (state_q == IDLE) && (op != 3'd0) && (op != 3'd7);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MTHI: hi_d = src_a;
                        OP_MTLO: lo_d = src_a;
                        default: begin
                            pend_d  = res;
                            cnt_d   = lat;
                            busy_d  = 1'b1;
                            state_d = RUN;
                        end
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    if (pend_q.wr) begin
                        hi_d = pend_q.hi;
                        lo_d = pend_q.lo;
                    end
                    cnt_d   = 4'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_q  <= '{hi: 32'd0, lo: 32'd0, wr: 1'b0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: vector table for single commands plus hand sequences for flush/busy/reset cases.
module tb_md_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        req;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .req   (req),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one command, count busy cycles, then check commit and single-cycle done.
    task automatic run_cmd(input string name, input logic [2:0] c_op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] e_hi, input logic [31:0] e_lo,
                           input int e_n);
        int n;
        start = 1'b1; op = c_op; src_a = a; src_b = b;
        tick();
        start = 1'b0; src_a = 32'h0BAD_0BAD; src_b = 32'h0BAD_0BAD;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        check({name, " busy_cycles"}, n, e_n);
        check({name, " hi"}, hi, e_hi);
        check({name, " lo"}, lo, e_lo);
        if (e_n > 0) begin
            check({name, " done"}, {31'd0, done}, 32'd1);
            tick();
            check({name, " done_drop"}, {31'd0, done}, 32'd0);
        end else begin
            check({name, " no_done"}, {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        int n;
        int done_cnt;

        vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFE, 5};
        vecs[1]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 5};
        vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[4]  = '{3'd4, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E, 10};
        vecs[5]  = '{3'd5, 32'hAAAA_5555, 32'd9,        32'hAAAA_5555, 32'h0000_000E, 0};
        vecs[6]  = '{3'd6, 32'h1234_5678, 32'd9,        32'hAAAA_5555, 32'h1234_5678, 0};
        vecs[7]  = '{3'd4, 32'd100,       32'd0,        32'hAAAA_5555, 32'h1234_5678, 10};
        vecs[8]  = '{3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
        vecs[9]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
        vecs[10] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[11] = '{3'd0, 32'h5555_AAAA, 32'd3,        32'h0000_0001, 32'hFFFF_FFFD, 0};

        reset = 1'b0; start = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0; req = 1'b0;
        tick();
        tick();
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].hi, vecs[i].lo, vecs[i].n);
            tick();
        end

        // req in the same cycle as start flushes the command
        start = 1'b1; req = 1'b1; op = 3'd6; src_a = 32'h1234_5678;
        tick();
        check("flush mtlo lo", lo, 32'hFFFF_FFFD);
        check("flush mtlo busy", {31'd0, busy}, 32'd0);
        op = 3'd1; src_a = 32'd3; src_b = 32'd4;
        tick();
        check("flush mult busy", {31'd0, busy}, 32'd0);
        check("flush mult done", {31'd0, done}, 32'd0);
        start = 1'b0; req = 1'b0;
        tick();
        check("flush idle busy", {31'd0, busy}, 32'd0);

        // mthi during RUN is ignored, then a back-to-back command right at the done cycle
        start = 1'b1; op = 3'd1; src_a = 32'd3; src_b = 32'd4;
        tick();
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n <= 2) begin
                start = 1'b1; op = 3'd5; src_a = 32'hDEAD_BEEF; src_b = 32'd77;
            end else begin
                start = 1'b0;
            end
            tick();
            if (n == 2) check("busy mthi hi held", hi, 32'h0000_0001);
        end
        start = 1'b0;
        check("busy mthi cycles", n, 5);
        check("busy mthi hi", hi, 32'd0);
        check("busy mthi lo", lo, 32'd12);
        check("busy mthi done", {31'd0, done}, 32'd1);
        start = 1'b1; op = 3'd1; src_a = 32'd2; src_b = 32'd3;
        tick();
        start = 1'b0;
        check("b2b busy", {31'd0, busy}, 32'd1);
        check("b2b done drop", {31'd0, done}, 32'd0);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        check("b2b cycles", n, 5);
        check("b2b lo", lo, 32'd6);
        check("b2b done", {31'd0, done}, 32'd1);
        tick();

        // req during RUN does not cancel
        start = 1'b1; op = 3'd4; src_a = 32'd9; src_b = 32'd2;
        tick();
        start = 1'b0; req = 1'b1;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        req = 1'b0;
        check("req run cycles", n, 10);
        check("req run hi", hi, 32'd1);
        check("req run lo", lo, 32'd4);
        check("req run done", {31'd0, done}, 32'd1);
        tick();

        // reset asserted on the third busy cycle of a mult
        start = 1'b1; op = 3'd1; src_a = 32'd5; src_b = 32'd6;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("mid reset busy before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        tick();
        check("mid reset busy", {31'd0, busy}, 32'd0);
        check("mid reset hi", hi, 32'd0);
        check("mid reset lo", lo, 32'd0);
        check("mid reset done", {31'd0, done}, 32'd0);
        reset = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done || busy) done_cnt++;
        end
        check("post reset quiet", done_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
